// File: rtl/dma_read_req_arbiter.sv
// dma_read_req_arbiter
// Shares one DMA read request port among P_REQUESTERS read paths. Paths are
// granted round-robin, and each grant takes the lowest free PCIe read tag from
// a pool of P_TAGS. A tag stays outstanding until its last completion beat arrives.
// Optional feature: define DRA_TIMEOUT_EN to reclaim a tag that has been
// outstanding for P_TIMEOUT cycles. That build adds the timeout_err and
// timeout_tag ports.
module dma_read_req_arbiter #(
    parameter int P_REQUESTERS = 2,
    parameter int P_TAGS       = 8,
    parameter int P_TIMEOUT    = 4096
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [P_REQUESTERS-1:0]     req_valid,
    input  logic [32*P_REQUESTERS-1:0]  req_addr,
    input  logic [10*P_REQUESTERS-1:0]  req_len,
    output logic [P_REQUESTERS-1:0]     req_ready,
    output logic [7:0]                  req_tag,
    output logic [31:0]                 dma_read_addr,
    output logic [9:0]                  dma_read_len,
    output logic [7:0]                  dma_read_tag,
    output logic                        dma_read_valid,
    input  logic                        dma_read_done,
    input  logic                        cpl_valid,
    input  logic [7:0]                  cpl_tag,
    input  logic                        cpl_last,
    output logic [$clog2(P_TAGS):0]     tags_free,
    output logic                        busy,
    output logic                        err_spurious_cpl
`ifdef DRA_TIMEOUT_EN
    ,
    output logic                        timeout_err,
    output logic [7:0]                  timeout_tag
`endif
);

    localparam int PTR_W    = (P_REQUESTERS > 1) ? $clog2(P_REQUESTERS) : 1;
    localparam int TF_W     = $clog2(P_TAGS) + 1;
    localparam int LAST_REQ = P_REQUESTERS - 1;
    localparam logic [PTR_W:0]   NREQ     = P_REQUESTERS[PTR_W:0];
    localparam logic [PTR_W-1:0] LAST_PTR = LAST_REQ[PTR_W-1:0];
    localparam logic [TF_W-1:0]  TAGS_CNT = P_TAGS[TF_W-1:0];

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [P_TAGS-1:0]         outstanding_q, outstanding_d;
    logic [P_REQUESTERS-1:0]   req_ready_q, req_ready_d;
    logic [7:0]                req_tag_q, req_tag_d;
    logic [31:0]               rd_addr_q, rd_addr_d;
    logic [9:0]                rd_len_q, rd_len_d;
    logic [7:0]                rd_tag_q, rd_tag_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [TF_W-1:0]           tags_free_q, tags_free_d;
    logic                      err_q, err_d;

    logic [P_REQUESTERS-1:0]   rot_valid;
    logic                      grant_found;
    logic [PTR_W-1:0]          grant_off;
    logic [PTR_W:0]            win_sum;
    logic [PTR_W-1:0]          grant_idx;
    logic                      free_found;
    logic [7:0]                free_idx;
    logic                      grant;
    logic [P_TAGS-1:0]         alloc_mask;
    logic [P_TAGS-1:0]         cpl_sel;
    logic [P_TAGS-1:0]         cpl_mask;
    logic                      cpl_hit;
    logic [P_TAGS-1:0]         tmo_mask;
    logic [TF_W-1:0]           used_cnt;

    // Round-robin winner: rotate req_valid so the pointer sits at bit 0, take
    // the lowest set bit, then rotate the offset back into a path index.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_off   = '0;
        rot_valid   = P_REQUESTERS'({req_valid, req_valid} >> rr_ptr_q);
        for (int i = P_REQUESTERS - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                grant_found = 1'b1;
                grant_off   = PTR_W'(i);
            end
        end
        win_sum   = {1'b0, rr_ptr_q} + {1'b0, grant_off};
        grant_idx = (win_sum >= NREQ) ? PTR_W'(win_sum - NREQ) : PTR_W'(win_sum);
    end

    // Lowest-index free tag, searched in the registered bitmap only.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int t = P_TAGS - 1; t >= 0; t--) begin
            if (!outstanding_q[t]) begin
                free_found = 1'b1;
                free_idx   = 8'(t);
            end
        end
    end

    // Completion decode. A tag >= P_TAGS shifts out of the mask and falls
    // through as spurious.
    always_comb begin
        cpl_sel  = P_TAGS'(1) << cpl_tag;
        cpl_hit  = cpl_valid && cpl_last && (|(cpl_sel & outstanding_q));
        cpl_mask = cpl_hit ? cpl_sel : '0;
        err_d    = err_q | (cpl_valid && cpl_last && !cpl_hit);
    end

    assign grant = (state_q == ST_IDLE) && grant_found && free_found;

    // FSM next state: grant in IDLE, then hold the issued request until it is accepted.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        req_ready_d = '0;
        req_tag_d   = req_tag_q;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        rd_tag_d    = rd_tag_q;
        rd_valid_d  = rd_valid_q;
        alloc_mask  = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    req_ready_d = P_REQUESTERS'(1) << grant_idx;
                    req_tag_d   = free_idx;
                    rd_addr_d   = req_addr[32*grant_idx +: 32];
                    rd_len_d    = req_len[10*grant_idx +: 10];
                    rd_tag_d    = free_idx;
                    rd_valid_d  = 1'b1;
                    alloc_mask  = P_TAGS'(1) << free_idx;
                    rr_ptr_d    = (grant_idx == LAST_PTR) ? '0 : grant_idx + 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dma_read_done) begin
                    rd_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bitmap update and free count. Allocation and free can land on the same
    // edge, and they never target the same tag.
    always_comb begin
        outstanding_d = (outstanding_q | alloc_mask) & ~cpl_mask & ~tmo_mask;
        used_cnt      = '0;
        for (int t = 0; t < P_TAGS; t++) begin
            used_cnt = used_cnt + TF_W'(outstanding_d[t]);
        end
        tags_free_d = TAGS_CNT - used_cnt;
    end

    // State and output registers; reset drops every outstanding tag at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            req_ready_q   <= '0;
            req_tag_q     <= '0;
            rd_addr_q     <= '0;
            rd_len_q      <= '0;
            rd_tag_q      <= '0;
            rd_valid_q    <= 1'b0;
            tags_free_q   <= TAGS_CNT;
            err_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            req_ready_q   <= req_ready_d;
            req_tag_q     <= req_tag_d;
            rd_addr_q     <= rd_addr_d;
            rd_len_q      <= rd_len_d;
            rd_tag_q      <= rd_tag_d;
            rd_valid_q    <= rd_valid_d;
            tags_free_q   <= tags_free_d;
            err_q         <= err_d;
        end
    end

`ifdef DRA_TIMEOUT_EN
    localparam int CNT_W    = $clog2(P_TIMEOUT) + 1;
    localparam int TMO_LAST = P_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = TMO_LAST[CNT_W-1:0];

    logic [CNT_W-1:0] tmo_cnt_q [P_TAGS];
    logic             tmo_found;
    logic [7:0]       tmo_idx;
    logic             tmo_err_q;
    logic [7:0]       tmo_tag_q;

    // Lowest expired tag. A completion freeing the same tag on this edge takes precedence.
    always_comb begin
        tmo_found = 1'b0;
        tmo_idx   = '0;
        for (int t = P_TAGS - 1; t >= 0; t--) begin
            if (outstanding_q[t] && (tmo_cnt_q[t] == CNT_LIMIT) && !cpl_mask[t]) begin
                tmo_found = 1'b1;
                tmo_idx   = 8'(t);
            end
        end
        tmo_mask = tmo_found ? (P_TAGS'(1) << tmo_idx) : '0;
    end

    // Per-tag age counters. They saturate at the limit, so tags that expire
    // together are released one per cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the counter array is reset explicitly because a stale count would reclaim a fresh tag early.
            for (int t = 0; t < P_TAGS; t++) begin
                tmo_cnt_q[t] <= '0;
            end
            tmo_err_q <= 1'b0;
            tmo_tag_q <= '0;
        end else begin
            for (int t = 0; t < P_TAGS; t++) begin
                if (alloc_mask[t]) begin
                    tmo_cnt_q[t] <= '0;
                end else if (outstanding_q[t] && (tmo_cnt_q[t] != CNT_LIMIT)) begin
                    tmo_cnt_q[t] <= tmo_cnt_q[t] + 1'b1;
                end
            end
            tmo_err_q <= tmo_found;
            if (tmo_found) begin
                tmo_tag_q <= tmo_idx;
            end
        end
    end

    assign timeout_err = tmo_err_q;
    assign timeout_tag = tmo_tag_q;
`else
    assign tmo_mask = '0;
`endif

    assign req_ready        = req_ready_q;
    assign req_tag          = req_tag_q;
    assign dma_read_addr    = rd_addr_q;
    assign dma_read_len     = rd_len_q;
    assign dma_read_tag     = rd_tag_q;
    assign dma_read_valid   = rd_valid_q;
    assign tags_free        = tags_free_q;
    assign busy             = (state_q != ST_IDLE) || (|outstanding_q);
    assign err_spurious_cpl = err_q;

endmodule

// File: tb/tb_dma_read_req_arbiter.sv
// Testbench for dma_read_req_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model of the grant/tag rules.
`timescale 1ns/1ps
module tb_dma_read_req_arbiter;
    localparam int N  = 2;
    localparam int T  = 8;
    localparam int TW = $clog2(T) + 1;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_addr;
    logic [10*N-1:0]   req_len;
    logic [N-1:0]      req_ready;
    logic [7:0]        req_tag;
    logic [31:0]       dma_read_addr;
    logic [9:0]        dma_read_len;
    logic [7:0]        dma_read_tag;
    logic              dma_read_valid;
    logic              dma_read_done;
    logic              cpl_valid;
    logic [7:0]        cpl_tag;
    logic              cpl_last;
    logic [TW-1:0]     tags_free;
    logic              busy;
    logic              err_spurious_cpl;
`ifdef DRA_TIMEOUT_EN
    logic              timeout_err;
    logic [7:0]        timeout_tag;
`endif

    dma_read_req_arbiter #(.P_REQUESTERS(N), .P_TAGS(T), .P_TIMEOUT(4096)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .req_ready        (req_ready),
        .req_tag          (req_tag),
        .dma_read_addr    (dma_read_addr),
        .dma_read_len     (dma_read_len),
        .dma_read_tag     (dma_read_tag),
        .dma_read_valid   (dma_read_valid),
        .dma_read_done    (dma_read_done),
        .cpl_valid        (cpl_valid),
        .cpl_tag          (cpl_tag),
        .cpl_last         (cpl_last),
        .tags_free        (tags_free),
        .busy             (busy),
        .err_spurious_cpl (err_spurious_cpl)
`ifdef DRA_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err),
        .timeout_tag      (timeout_tag)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_out [T];
    int           m_rr    = 0;
    bit           m_issue = 1'b0;
    logic [N-1:0] m_ready = '0;
    logic [7:0]   m_tag   = '0;
    logic [31:0]  m_addr  = '0;
    logic [9:0]   m_len   = '0;
    logic [7:0]   m_dtag  = '0;
    bit           m_err   = 1'b0;
    int           m_win, m_ftag, m_k;

    function automatic int m_free_cnt();
        int n = 0;
        for (int t = 0; t < T; t++) if (!m_out[t]) n++;
        return n;
    endfunction

    function automatic bit m_busy();
        return m_issue || (m_free_cnt() != T);
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int t = 0; t < T; t++) m_out[t] = 1'b0;
            m_rr = 0; m_issue = 1'b0; m_ready = '0; m_tag = '0;
            m_addr = '0; m_len = '0; m_dtag = '0; m_err = 1'b0;
        end else begin
            m_win  = -1;
            m_ftag = -1;
            if (!m_issue) begin
                for (int i = 0; i < N; i++) begin
                    m_k = (m_rr + i) % N;
                    if (m_win < 0 && req_valid[m_k]) m_win = m_k;
                end
                for (int t = 0; t < T; t++) if (m_ftag < 0 && !m_out[t]) m_ftag = t;
            end
            m_ready = '0;
            if (cpl_valid && cpl_last) begin
                if (int'(cpl_tag) < T && m_out[cpl_tag]) m_out[cpl_tag] = 1'b0;
                else m_err = 1'b1;
            end
            if (m_issue && dma_read_done) m_issue = 1'b0;
            if (m_win >= 0 && m_ftag >= 0) begin
                m_ready[m_win] = 1'b1;
                m_tag  = 8'(m_ftag);
                m_dtag = 8'(m_ftag);
                m_addr = req_addr[32*m_win +: 32];
                m_len  = req_len[10*m_win +: 10];
                m_out[m_ftag] = 1'b1;
                m_issue = 1'b1;
                m_rr = (m_win + 1) % N;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("req_ready", req_ready, m_ready);
            if (m_ready != '0) check("req_tag", req_tag, m_tag);
            check("dma_read_valid", dma_read_valid, m_issue);
            check("dma_read_addr", dma_read_addr, m_addr);
            check("dma_read_len", dma_read_len, m_len);
            check("dma_read_tag", dma_read_tag, m_dtag);
            check("tags_free", tags_free, m_free_cnt());
            check("busy", busy, m_busy());
            check("err_spurious_cpl", err_spurious_cpl, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic new_req(input int k);
        req_valid[k] = 1'b1;
        req_addr[32*k +: 32] = $urandom;
        req_len[10*k +: 10]  = 10'($urandom_range(0, 1023));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_req_tag"}, req_tag, 0);
        check({tag, "_valid"}, dma_read_valid, 0);
        check({tag, "_addr"}, dma_read_addr, 0);
        check({tag, "_len"}, dma_read_len, 0);
        check({tag, "_dtag"}, dma_read_tag, 0);
        check({tag, "_err"}, err_spurious_cpl, 0);
        check({tag, "_tags_free"}, tags_free, T);
        check({tag, "_busy"}, busy, 0);
    endtask

    int gw[$];
    int gt[$];
    int cand[$];

    initial begin
        i_rst = 1'b0;
        req_valid = '0; req_addr = '0; req_len = '0;
        dma_read_done = 1'b0; cpl_valid = 1'b0; cpl_tag = '0; cpl_last = 1'b0;
        #1 i_rst = 1'b1;
        #1 check_reset_outputs("rst0");
        @(negedge i_clk);
        i_rst = 1'b0;

        // Single request on path 0.
        @(negedge i_clk);
        req_valid = 2'b01; req_addr[31:0] = 32'h1000_0000; req_len[9:0] = 10'd32;
        @(negedge i_clk);
        check("t1_ready", req_ready, 2'b01);
        check("t1_tag", req_tag, 0);
        check("t1_valid", dma_read_valid, 1);
        check("t1_addr", dma_read_addr, 32'h1000_0000);
        check("t1_len", dma_read_len, 32);
        check("t1_tags_free", tags_free, 7);
        req_valid = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        dma_read_done = 1'b1;
        @(negedge i_clk);
        dma_read_done = 1'b0;
        check("t1_done_valid", dma_read_valid, 0);
        check("t1_done_busy", busy, 1);
        check("t1_done_tags_free", tags_free, 7);
        cpl_valid = 1'b1; cpl_last = 1'b1; cpl_tag = 8'd0;
        @(negedge i_clk);
        cpl_valid = 1'b0; cpl_last = 1'b0;
        check("t1_cpl_tags_free", tags_free, 8);
        check("t1_cpl_busy", busy, 0);

        // Fairness, then pool exhaustion and re-grant.
        do_reset();
        req_valid = 2'b11;
        req_addr = {32'hB000_0000, 32'hA000_0000};
        req_len  = {10'd7, 10'd0};
        dma_read_done = 1'b1;
        for (int c = 0; c < 60 && gw.size() < T; c++) begin
            @(negedge i_clk);
            if (req_ready != '0) begin
                gw.push_back(req_ready == 2'b01 ? 0 : 1);
                gt.push_back(int'(req_tag));
            end
        end
        check("fair_grant_count", gw.size(), T);
        for (int i = 0; i < gw.size(); i++) begin
            check($sformatf("fair_winner%0d", i), gw[i], i % 2);
            check($sformatf("fair_tag%0d", i), gt[i], i);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check("exh_no_grant", req_ready, 0);
            check("exh_tags_free", tags_free, 0);
        end
        cpl_valid = 1'b1; cpl_last = 1'b1; cpl_tag = 8'd1;
        @(negedge i_clk);
        cpl_valid = 1'b0; cpl_last = 1'b0;
        check("exh_free_no_grant", req_ready, 0);
        check("exh_free_count", tags_free, 1);
        @(negedge i_clk);
        check("exh_regrant", req_ready != '0, 1);
        check("exh_regrant_tag", req_tag, 1);
        req_valid = '0;
        dma_read_done = 1'b0;

        // Spurious completion sets a sticky error.
        do_reset();
        cpl_valid = 1'b1; cpl_last = 1'b1; cpl_tag = 8'd5;
        @(negedge i_clk);
        cpl_valid = 1'b0; cpl_last = 1'b0;
        check("spur_err", err_spurious_cpl, 1);
        check("spur_tags_free", tags_free, 8);
        repeat (3) @(negedge i_clk);
        check("spur_sticky", err_spurious_cpl, 1);

        // Async reset while in ISSUE with 3 tags outstanding.
        do_reset();
        gw.delete();
        req_valid = 2'b01;
        dma_read_done = 1'b1;
        for (int c = 0; c < 30 && gw.size() < 3; c++) begin
            @(negedge i_clk);
            if (req_ready != '0) gw.push_back(0);
        end
        check("ar_grants", gw.size(), 3);
        req_valid = '0;
        dma_read_done = 1'b0;
        @(negedge i_clk);
        check("ar_pre_valid", dma_read_valid, 1);
        check("ar_pre_tags_free", tags_free, 5);
        #2 i_rst = 1'b1;
        #1 check_reset_outputs("ar");
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("ar_post_tags_free", tags_free, 8);
        check("ar_post_busy", busy, 0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge i_clk);
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    if ($urandom_range(0, 1) == 1) new_req(k);
                    else req_valid[k] = 1'b0;
                end else if (req_valid[k]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(k);
                end
            end
            dma_read_done = ($urandom_range(0, 2) == 0);
            cand.delete();
            for (int t = 0; t < T; t++) if (m_out[t]) cand.push_back(t);
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                cpl_valid = 1'b1;
                cpl_tag   = 8'(cand[$urandom_range(0, cand.size() - 1)]);
                cpl_last  = ($urandom_range(0, 3) != 0);
            end else begin
                cpl_valid = ($urandom_range(0, 4) == 0);
                cpl_tag   = 8'($urandom);
                cpl_last  = 1'b0;
            end
        end
        req_valid = '0; cpl_valid = 1'b0; dma_read_done = 1'b0;
        @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got time %0t, expected < 200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/dma_read_req_arbiter.md
Name: dma_read_req_arbiter

Overview:
- Shares the single DMA read request port (addr/len/valid/done) among P_REQUESTERS independent read paths.
- Grants requesters by round-robin and allocates a PCIe read tag to each granted request from a pool of P_TAGS tags.
- Tracks outstanding tags and frees each one on the last completion for that tag; blocks new grants when the pool is empty.
- Sits between the per-path request logic and the PCIe read requester.

Parameters:
P_REQUESTERS, 2, number of requesting paths (1..8)
P_TAGS, 8, tag pool size, i.e. maximum outstanding reads (1..32); tags issued are 0..P_TAGS-1
P_TIMEOUT, 4096, cycles before an outstanding tag is reclaimed (used only with DRA_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
req_valid  in  P_REQUESTERS  per-path request pending
req_addr  in  32*P_REQUESTERS  host address, path k at bits [32k+31:32k]
req_len  in  10*P_REQUESTERS  length in DW, path k at bits [10k+9:10k]; 0 means 1024 DW
req_ready  out  P_REQUESTERS  one-hot, one-cycle grant pulse
req_tag  out  8  tag assigned to the granted request; valid while req_ready!=0
dma_read_addr  out  32  issued host address
dma_read_len  out  10  issued length
dma_read_tag  out  8  issued tag
dma_read_valid  out  1  request valid to the PCIe requester
dma_read_done  in  1  requester accepted the current request
cpl_valid  in  1  completion beat present
cpl_tag  in  8  tag of the completion beat
cpl_last  in  1  final beat for this tag
tags_free  out  $clog2(P_TAGS)+1  count of free tags
busy  out  1  state!=IDLE or any tag outstanding
err_spurious_cpl  out  1  sticky; set by a completion whose tag is not outstanding

Behaviour:
- Reset: state=IDLE, outstanding bitmap=0, round-robin pointer=0.
- Reset output values: req_ready=0, req_tag=0, dma_read_valid=0, dma_read_addr/len/tag=0, err_spurious_cpl=0, tags_free=P_TAGS, busy=0.
- Reset asserted mid-operation aborts everything immediately; all outstanding tags are forgotten.
- State machine, IDLE:
  - A grant occurs when |req_valid and at least one tag is free.
  - Winner = first set req_valid bit at or after the round-robin pointer, wrapping.
  - Tag = lowest-index free tag.
  - On the grant edge, all registered: req_ready[winner]=1 for one cycle; req_tag=tag; dma_read_addr/len latched from the winner's slice; dma_read_tag=tag; outstanding[tag]=1; dma_read_valid=1; state goes to ISSUE.
  - Round-robin pointer = winner+1 mod P_REQUESTERS.
- State machine, ISSUE:
  - dma_read_valid and the dma_read_* outputs are held stable.
  - On the edge where dma_read_done=1: dma_read_valid=0 and state goes to IDLE.
  - The earliest next grant is on the following edge, giving a minimum of 2 cycles between grants.
- Requester rules:
  - Hold req_valid, addr and len stable until req_ready is seen.
  - The request is consumed in the req_ready cycle; deassert req_valid the next cycle or present a new request.
  - req_valid dropped before grant is legal; that path is simply not considered.
- Completion handling:
  - cpl_valid && cpl_last && cpl_tag<P_TAGS && outstanding[cpl_tag] clears that bit on the edge.
  - Non-last beats have no effect.
  - cpl_valid && cpl_last for a non-outstanding tag or cpl_tag>=P_TAGS is ignored and sets err_spurious_cpl.
- Simultaneous allocation and free on the same edge:
  - Both apply; tags_free on the next cycle reflects the net change.
  - A tag freed on edge N is allocatable from edge N+1 (the lowest-free search uses the registered bitmap).
- Pool empty: no grant and req_ready stays 0; completions still free tags.
- tags_free = P_TAGS - popcount(outstanding), registered, updated on the same edge as the bitmap.
- dma_read_done while in IDLE is ignored.

Optional Feature:
- DRA_TIMEOUT_EN defined:
  - Each outstanding tag has a counter that resets at allocation and increments every cycle.
  - When a counter reaches P_TIMEOUT-1, the tag is freed.
  - Ports timeout_err (1 bit, one-cycle pulse) and timeout_tag (8 bits) report the freed tag.
  - If several tags time out in the same cycle, the lowest index is reported that cycle and the others in subsequent cycles.
  - A completion that frees a tag on the same edge as its timeout wins, with no timeout_err.
- DRA_TIMEOUT_EN undefined: the counters and both ports are absent and tags are freed only by completions.

Test Plan:
- Single request: path0 addr=0x1000_0000 len=32 -> req_ready=2'b01 and dma_read_valid=1 one cycle later, tag=0; done 3 cycles later -> valid drops, busy=1, tags_free=7; cpl_last tag0 -> tags_free=8, busy=0.
- Fairness: both paths valid continuously with fast done -> grants alternate 0,1,0,1 with tags 0,1,2,3.
- Pool exhaustion with P_TAGS=2: 3 requests -> only 2 grants; cpl_last tag1 -> third grant receives tag 1 on the cycle after the free.
- Spurious completion: cpl_last tag 5 while none outstanding -> err_spurious_cpl=1 and stays set; tags_free unchanged.
- Async reset asserted in ISSUE with 3 tags outstanding -> all outputs reach reset values without a clock edge; after release tags_free=8.
- DRA_TIMEOUT_EN with P_TIMEOUT=16: grant tag0 and send no completion -> timeout_err pulse with timeout_tag=0 16 cycles after allocation; tags_free returns to 8.
